// File: rtl/lsu_pkg.sv
// Shared LSU definitions: AXI response codes, read-collector state encoding
// and the default read-beat widths.
package lsu_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned LSU_DATA_WIDTH = 64;
  localparam int unsigned LSU_ID_WIDTH   = 8;

  typedef enum logic [1:0] {
    COL_IDLE    = 2'd0,
    COL_COLLECT = 2'd1,
    COL_DRAIN   = 2'd2,
    COL_DONE    = 2'd3
  } col_state_e;

endpackage

// File: rtl/rd_collect_fifo.sv
// Generic synchronous FIFO with wrapping pointers; full/empty come from a
// separate occupancy count one bit wider than the pointers.
module rd_collect_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lsu_rd_collect.sv
// Collects a descriptor's worth of AXI read beats into a small FIFO, tags the
// final beat and reports one completion pulse with sticky error.
module lsu_rd_collect
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int unsigned ID_WIDTH   = LSU_ID_WIDTH,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_req_vld,
  output logic                  ld_req_rdy,
  input  logic [CNT_WIDTH-1:0]  ld_req_beats,
  input  logic [ID_WIDTH-1:0]   axi_lsu_rid,
  input  logic [DATA_WIDTH-1:0] axi_lsu_rdata,
  input  logic [1:0]            axi_lsu_rresp,
  input  logic                  axi_lsu_rlast,
  input  logic                  axi_lsu_rvld,
  output logic                  lsu_axi_rrdy,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic                  out_burst_last,
  output logic                  out_last,
  output logic                  done_vld,
  output logic                  done_err,
  output logic                  busy
);

  localparam int unsigned EW  = DATA_WIDTH + ID_WIDTH + 2;
  localparam int unsigned FCW = $clog2(DEPTH) + 1;

  col_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] beats_q, beats_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 accept, pop, desc_last, beat_err;
  logic                 fifo_full, fifo_empty;
  logic [FCW-1:0]       fifo_count;
  logic [EW-1:0]        fifo_din, fifo_dout;

  // Upstream ready depends only on registered state and FIFO occupancy.
  assign lsu_axi_rrdy = (state_q == COL_COLLECT) & ~fifo_full;
  assign accept       = axi_lsu_rvld & lsu_axi_rrdy;
  assign out_vld      = ~fifo_empty;
  assign pop          = out_vld & out_rdy;
  assign desc_last    = (cnt_q == (beats_q - CNT_WIDTH'(1)));
  assign beat_err     = (axi_lsu_rresp == AXI_RESP_SLVERR) ||
                        (axi_lsu_rresp == AXI_RESP_DECERR);

  assign fifo_din = {axi_lsu_rdata, axi_lsu_rid, axi_lsu_rlast, desc_last};
  assign {out_data, out_id, out_burst_last, out_last} = fifo_dout;

  rd_collect_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COL_IDLE;
      beats_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beats_d    = beats_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    ld_req_rdy = 1'b0;
    done_vld   = 1'b0;
    done_err   = 1'b0;
    busy       = 1'b1;
    case (state_q)
      COL_IDLE: begin
        busy       = 1'b0;
        ld_req_rdy = 1'b1;
        if (ld_req_vld) begin
          beats_d = ld_req_beats;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = (ld_req_beats != '0) ? COL_COLLECT : COL_DONE;
        end
      end
      COL_COLLECT: begin
        if (accept) begin
          if (beat_err) err_d = 1'b1;
          // Counter holds at beats-1; the final accept moves on to drain.
          if (desc_last) state_d = COL_DRAIN;
          else           cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
      end
      COL_DRAIN: begin
        if (pop && (fifo_count == FCW'(1))) state_d = COL_DONE;
      end
      COL_DONE: begin
        done_vld = 1'b1;
        done_err = err_q;
        state_d  = COL_IDLE;
      end
      default: state_d = COL_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_rd_collect.sv
// Directed bench for lsu_rd_collect: table of descriptors checked against a
// cycle model of FIFO occupancy, plus reset sequences.
module tb_lsu_rd_collect;
  import lsu_pkg::*;

  localparam int DEP = 4;

  logic        clk;
  logic        rst_n;
  logic        ld_req_vld;
  logic        ld_req_rdy;
  logic [7:0]  ld_req_beats;
  logic [7:0]  axi_lsu_rid;
  logic [63:0] axi_lsu_rdata;
  logic [1:0]  axi_lsu_rresp;
  logic        axi_lsu_rlast;
  logic        axi_lsu_rvld;
  logic        lsu_axi_rrdy;
  logic        out_vld;
  logic        out_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_id;
  logic        out_burst_last;
  logic        out_last;
  logic        done_vld;
  logic        done_err;
  logic        busy;

  int checks;
  int errors;

  typedef struct {
    int         nb;
    int         err_idx;
    logic [1:0] eresp;
    int         hold;
    bit         toggle;
    bit         exp_err;
  } vec_t;

  vec_t vecs[10];

  lsu_rd_collect dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ld_req_vld     (ld_req_vld),
    .ld_req_rdy     (ld_req_rdy),
    .ld_req_beats   (ld_req_beats),
    .axi_lsu_rid    (axi_lsu_rid),
    .axi_lsu_rdata  (axi_lsu_rdata),
    .axi_lsu_rresp  (axi_lsu_rresp),
    .axi_lsu_rlast  (axi_lsu_rlast),
    .axi_lsu_rvld   (axi_lsu_rvld),
    .lsu_axi_rrdy   (lsu_axi_rrdy),
    .out_vld        (out_vld),
    .out_rdy        (out_rdy),
    .out_data       (out_data),
    .out_id         (out_id),
    .out_burst_last (out_burst_last),
    .out_last       (out_last),
    .done_vld       (done_vld),
    .done_err       (done_err),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk64(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int d, input int i);
    return {32'(d) + 32'hC0DE_0000, 32'(i) * 32'h0101_0101 + 32'h0000_1000};
  endfunction

  function automatic logic [7:0] idp(input int d, input int i);
    return 8'(d * 16 + i);
  endfunction

  // Runs one descriptor; the model tracks accepted-minus-popped beats.
  task automatic run_desc(input int d, input vec_t v);
    int  sent, popped, mcount, last_pop;
    bit  seen_done, acc, pp;
    chk1("ld_req_rdy_idle", ld_req_rdy, 1'b1);
    ld_req_vld   = 1'b1;
    ld_req_beats = 8'(v.nb);
    step();
    ld_req_vld = 1'b0;
    chk1("busy_start", busy, 1'b1);
    chk1("ld_req_rdy_busy", ld_req_rdy, 1'b0);
    sent = 0; popped = 0; mcount = 0; last_pop = -1; seen_done = 1'b0;
    for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
      axi_lsu_rvld  = (sent < v.nb);
      axi_lsu_rdata = pat(d, sent);
      axi_lsu_rid   = idp(d, sent);
      axi_lsu_rlast = 1'((sent % 2) == 1);
      if (sent == v.err_idx)  axi_lsu_rresp = v.eresp;
      else if (sent % 3 == 2) axi_lsu_rresp = AXI_RESP_EXOKAY;
      else                    axi_lsu_rresp = AXI_RESP_OKAY;
      out_rdy = v.toggle ? ((cyc % 3) != 1) : (cyc >= v.hold);
      chk1("rrdy", lsu_axi_rrdy, (sent < v.nb) && (mcount < DEP));
      chk1("out_vld", out_vld, mcount > 0);
      if (done_vld) begin
        seen_done = 1'b1;
        chk1("done_err", done_err, v.exp_err);
        chki("done_pops", popped, v.nb);
        chki("done_latency", cyc, last_pop + 1);
      end else begin
        acc = axi_lsu_rvld && lsu_axi_rrdy;
        pp  = out_vld && out_rdy;
        if (pp) begin
          chk64("out_data", out_data, pat(d, popped));
          chk64("out_id", 64'(out_id), 64'(idp(d, popped)));
          chk1("out_burst_last", out_burst_last, (popped % 2) == 1);
          chk1("out_last", out_last, popped == v.nb - 1);
          last_pop = cyc;
          popped++;
        end
        if (acc) sent++;
        mcount = mcount + int'(acc) - int'(pp);
        step();
      end
    end
    if (!seen_done) chk1("done_timeout", 1'b0, 1'b1);
    axi_lsu_rvld = 1'b0;
    out_rdy      = 1'b0;
    step();
    chk1("done_one_cycle", done_vld, 1'b0);
    chk1("ld_req_rdy_after", ld_req_rdy, 1'b1);
    chk1("busy_after", busy, 1'b0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    ld_req_vld    = 1'b0;
    ld_req_beats  = '0;
    axi_lsu_rid   = '0;
    axi_lsu_rdata = '0;
    axi_lsu_rresp = '0;
    axi_lsu_rlast = 1'b0;
    axi_lsu_rvld  = 1'b1;
    out_rdy       = 1'b1;

    vecs[0] = '{3,  -1, AXI_RESP_OKAY,   0, 1'b0, 1'b0};
    vecs[1] = '{6,  -1, AXI_RESP_OKAY,   8, 1'b0, 1'b0};
    vecs[2] = '{4,   1, AXI_RESP_SLVERR, 0, 1'b0, 1'b1};
    vecs[3] = '{4,  -1, AXI_RESP_OKAY,   0, 1'b0, 1'b0};
    vecs[4] = '{0,  -1, AXI_RESP_OKAY,   0, 1'b0, 1'b0};
    vecs[5] = '{12, -1, AXI_RESP_OKAY,   2, 1'b0, 1'b0};
    vecs[6] = '{5,   4, AXI_RESP_DECERR, 0, 1'b1, 1'b1};
    vecs[7] = '{7,   2, AXI_RESP_EXOKAY, 0, 1'b1, 1'b0};
    vecs[8] = '{1,   0, AXI_RESP_SLVERR, 0, 1'b0, 1'b1};
    vecs[9] = '{2,  -1, AXI_RESP_OKAY,   0, 1'b0, 1'b0};

    // Reset values, even with valid beats and consumer ready applied.
    #12;
    chk1("rst_ld_req_rdy", ld_req_rdy, 1'b1);
    chk1("rst_rrdy", lsu_axi_rrdy, 1'b0);
    chk1("rst_out_vld", out_vld, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done_vld", done_vld, 1'b0);
    chk64("rst_out_data", out_data, 64'd0);
    step();
    rst_n        = 1'b1;
    axi_lsu_rvld = 1'b0;
    step();
    chk1("idle_rrdy", lsu_axi_rrdy, 1'b0);

    for (int i = 0; i < 10; i++) run_desc(i + 1, vecs[i]);

    // Reset mid-collect with two beats buffered.
    ld_req_vld   = 1'b1;
    ld_req_beats = 8'd5;
    step();
    ld_req_vld = 1'b0;
    out_rdy    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      axi_lsu_rvld  = 1'b1;
      axi_lsu_rdata = pat(50, i);
      axi_lsu_rid   = idp(50, i);
      axi_lsu_rresp = AXI_RESP_OKAY;
      axi_lsu_rlast = 1'b0;
      chk1("mid_rrdy", lsu_axi_rrdy, 1'b1);
      step();
    end
    axi_lsu_rvld = 1'b0;
    chk1("mid_out_vld", out_vld, 1'b1);
    chk64("mid_head", out_data, pat(50, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk1("mrst_out_vld", out_vld, 1'b0);
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_ld_req_rdy", ld_req_rdy, 1'b1);
    chk1("mrst_rrdy", lsu_axi_rrdy, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk1("mrst_no_done", done_vld, 1'b0);
      chk1("mrst_empty", out_vld, 1'b0);
      step();
    end

    run_desc(99, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
